alu_writeback: RTL
==================

# alu_writeback

Writeback stage directly downstream of the 16-bit `alu`. It accepts each ALU result (`out`, `c_out`) with a destination register index and holds it in a one-entry pending register. It commits the result into an 8 x 16-bit register file and the carry/zero flags. The load unit shares the single write port and has priority over ALU results. Two combinational read ports, with forwarding from the pending register, return operands to the ALU's `a_in`/`b_in` inputs.

## Interface
- `NREGS`, 8: register count; the index width is log2(NREGS), 3 at the default.
- `W`, 16: data width; matches the `alu` datapath.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `alu_valid` in 1: an ALU result is presented.
- `alu_ready` out 1: the stage accepts the result this cycle.
- `alu_out` in W: ALU result data.
- `alu_c_out` in 1: ALU carry out.
- `alu_dest` in 3: destination register index.
- `alu_flags_we` in 1: this result updates the flags.
- `ld_valid` in 1: load unit write request; never stalled.
- `ld_dest` in 3: load destination register index.
- `ld_data` in W: load data.
- `ra_addr`, `rb_addr` in 3 each: read port addresses.
- `ra_data`, `rb_data` out W each: read port data, combinational.
- `carry_flag` out 1: registered carry flag.
- `zero_flag` out 1: registered zero flag.
- `pend_valid` out 1: the pending register is occupied.

## Operation
- The pending register P holds {valid, data, dest, carry, flags_we}.
- Acceptance happens when `alu_valid && alu_ready`. The accepted result loads P at the edge.
- `alu_ready` = !P.valid || !ld_valid || (ld_dest == P.dest).
- Write port arbitration, evaluated each cycle:
  - If `ld_valid`: write `ld_data` to `ld_dest`.
  - Else if P.valid: P commits. It writes P.data to P.dest and clears P.valid, unless a new result is accepted at the same edge.
- Same-destination conflict (`ld_valid`, P.valid, `ld_dest == P.dest`):
  - The load is younger, so P's register write is squashed.
  - P retires this cycle.
  - P's flag update, if enabled, still applies.
- Flags: when P retires with P.flags_we set:
  - `carry_flag` <= P.carry.
  - `zero_flag` <= (P.data == 0).
  - Otherwise both flags hold.
- Read ports:
  - If P.valid and P.dest == addr, return P.data.
  - Otherwise return the register file contents.
  - A load is visible from the cycle after its write.
- Simultaneous retire and accept: a result may be accepted into P in the same cycle P retires. The stage sustains full throughput when there are no load writes.

## Timing
- Reset values:
  - All registers 0.
  - P.valid 0, so `pend_valid` 0 and `alu_ready` 1.
  - `carry_flag` 0, `zero_flag` 0.
  - `ra_data`/`rb_data` 0, since the register file is 0.
- Latency: a result accepted at edge N is readable through forwarding after edge N. It is in the register file after edge N+1 if there is no load that cycle.
- Each cycle of `ld_valid` to a different register delays a pending commit by one cycle. While P is blocked, `alu_ready` is low.
- Handshake rule: the ALU side holds its data stable while `alu_valid && !alu_ready`.
- A reset assertion mid-operation discards P immediately and clears all state asynchronously.

## Configuration
- `REG0_ZERO_EN` defined:
  - r0 always reads 0.
  - Writes to r0 from either source are dropped.
  - Forwarding never matches dest 0.
  - A flag update from a result targeting r0 still applies.
  - `alu_ready` logic is unchanged.
- Not defined: r0 is an ordinary register.

## Test plan
- Reset, then `alu_out`=0x0011, `alu_c_out`=0, dest 2, flags_we=1:
  - `ra_addr`=2 reads 0x0011 the next cycle through forwarding.
  - The register file holds it one cycle later.
  - `carry_flag`=0, `zero_flag`=0.
- `alu_out`=0xFFFF, `alu_c_out`=1, dest 3, flags_we=1, then `alu_out`=0x0000, c_out=1, dest 4:
  - After the first retire, `carry_flag`=1 and `zero_flag`=0.
  - After the second retire, `zero_flag`=1.
  - Back-to-back acceptance, with `alu_ready` held at 1.
- P holds 0x1234 to dest 5, then `ld_valid` to dest 1 for 3 cycles:
  - `alu_ready`=0 for those 3 cycles.
  - r5 is written the cycle after the load burst.
  - Forwarded reads of r5 return 0x1234 throughout.
- P holds 0xAAAA to dest 6 with flags_we=1, and `ld_valid` writes 0x5555 to dest 6 in the same cycle:
  - r6 = 0x5555.
  - `zero_flag`=0 and `carry_flag` taken from P.
  - P retires.
- Assert `rst_n` low asynchronously mid-clock while P is valid:
  - All outputs return to their reset values before the next edge.
  - No commit of P occurs.
- With `REG0_ZERO_EN`, write 0x00FF to dest 0:
  - `ra_addr`=0 reads 0x0000 both before and after the retire.
  - Flags still update.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry pending result P, 8x16 register file, carry/zero flags,
// forwarding read ports. Latency: forwardable after accept edge, committed one edge later.
// Backpressure: alu_ready drops only while P is blocked by a load to another register. Option: REG0_ZERO_EN.
module alu_writeback #(
   parameter int NREGS = 8,
   parameter int W     = 16,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [W-1:0]  alu_out,
   input  logic          alu_c_out,
   input  logic [AW-1:0] alu_dest,
   input  logic          alu_flags_we,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_dest,
   input  logic [W-1:0]  ld_data,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [W-1:0]  ra_data,
   output logic [W-1:0]  rb_data,
   output logic          carry_flag,
   output logic          zero_flag,
   output logic          pend_valid
);

   logic          p_vld_q, p_vld_d;
   logic [W-1:0]  p_dat_q, p_dat_d;
   logic [AW-1:0] p_dst_q, p_dst_d;
   logic          p_c_q,   p_c_d;
   logic          p_fwe_q, p_fwe_d;
   logic          carry_q, carry_d;
   logic          zero_q,  zero_d;
   logic [W-1:0]  rf_q [NREGS];

   logic          p_retire;
   logic          accept;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_dat;
   logic          fwd_a, fwd_b;

   // A load to P's own register is younger, so P retires with its write squashed.
   always_comb begin
      alu_ready = !p_vld_q || !ld_valid || (ld_dest == p_dst_q);
      p_retire  = p_vld_q && (!ld_valid || (ld_dest == p_dst_q));
      accept    = alu_valid && alu_ready;
   end

   always_comb begin
      p_vld_d = p_vld_q;
      p_dat_d = p_dat_q;
      p_dst_d = p_dst_q;
      p_c_d   = p_c_q;
      p_fwe_d = p_fwe_q;
      if (accept) begin
         p_vld_d = 1'b1;
         p_dat_d = alu_out;
         p_dst_d = alu_dest;
         p_c_d   = alu_c_out;
         p_fwe_d = alu_flags_we;
      end else if (p_retire) begin
         p_vld_d = 1'b0;
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_dat  = '0;
      if (ld_valid) begin
         wr_en   = 1'b1;
         wr_addr = ld_dest;
         wr_dat  = ld_data;
      end else if (p_vld_q) begin
         wr_en   = 1'b1;
         wr_addr = p_dst_q;
         wr_dat  = p_dat_q;
      end
`ifdef REG0_ZERO_EN
      if (wr_addr == '0) begin
         wr_en = 1'b0;
      end
`endif
   end

   always_comb begin
      carry_d = carry_q;
      zero_d  = zero_q;
      if (p_retire && p_fwe_q) begin
         carry_d = p_c_q;
         zero_d  = (p_dat_q == '0);
      end
   end

   always_comb begin
`ifdef REG0_ZERO_EN
      fwd_a   = p_vld_q && (p_dst_q == ra_addr) && (p_dst_q != '0);
      fwd_b   = p_vld_q && (p_dst_q == rb_addr) && (p_dst_q != '0);
      ra_data = fwd_a ? p_dat_q : rf_q[ra_addr];
      rb_data = fwd_b ? p_dat_q : rf_q[rb_addr];
      if (ra_addr == '0) begin
         ra_data = '0;
      end
      if (rb_addr == '0) begin
         rb_data = '0;
      end
`else
      fwd_a   = p_vld_q && (p_dst_q == ra_addr);
      fwd_b   = p_vld_q && (p_dst_q == rb_addr);
      ra_data = fwd_a ? p_dat_q : rf_q[ra_addr];
      rb_data = fwd_b ? p_dat_q : rf_q[rb_addr];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_vld_q <= 1'b0;
         p_dat_q <= '0;
         p_dst_q <= '0;
         p_c_q   <= 1'b0;
         p_fwe_q <= 1'b0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         p_vld_q <= p_vld_d;
         p_dat_q <= p_dat_d;
         p_dst_q <= p_dst_d;
         p_c_q   <= p_c_d;
         p_fwe_q <= p_fwe_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         if (wr_en) begin
            rf_q[wr_addr] <= wr_dat;
         end
      end
   end

   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;
   assign pend_valid = p_vld_q;

endmodule
